// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_pkg
//  Brief    : Shared types and constants for the LSU-to-bus bridge.
//  Revision : 1.0 - initial release
// ============================================================================
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } dbus_state_e;

    // Load data returned to the core when an access is abandoned.
    localparam logic [31:0] ERR_RDATA = 32'h0;

    function automatic logic state_busy(input dbus_state_e s);
        return (s == REQ) || (s == RESP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbus_if.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_if
//  Brief    : Request/response bus between the bridge (master) and memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface dbus_if #(
    parameter int DW = 32
);
    logic          bus_valid_o;
    logic          bus_ready_i;
    logic          bus_we_o;
    logic [DW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic [3:0]    bus_mask_o;
    logic          bus_rvalid_i;
    logic [DW-1:0] bus_rdata_i;

    modport master (
        output bus_valid_o,
        output bus_we_o,
        output bus_addr_o,
        output bus_wdata_o,
        output bus_mask_o,
        input  bus_ready_i,
        input  bus_rvalid_i,
        input  bus_rdata_i
    );

    modport slave (
        input  bus_valid_o,
        input  bus_we_o,
        input  bus_addr_o,
        input  bus_wdata_o,
        input  bus_mask_o,
        output bus_ready_i,
        output bus_rvalid_i,
        output bus_rdata_i
    );

endinterface
`default_nettype wire

// File: rtl/dbus_timeout.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_timeout
//  Brief    : Watchdog counting busy cycles; expired on the last allowed one.
//  Revision : 1.0 - initial release
// ============================================================================
module dbus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int C_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(TIMEOUT_CYCLES - 1);

    logic [C_CW-1:0] r_count;

    // Counter holds the index of the current busy cycle, so the limit is
    // reached during the TIMEOUT_CYCLES-th cycle rather than one later.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != C_LAST)) begin
            r_count <= r_count + C_CW'(1);
        end
    end

    assign expired = enable && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/dbus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_bridge
//  Brief    : Stalls the core while one load/store is carried over the bus.
//             Optional watchdog enabled by defining DBUS_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [DW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    input  logic [3:0]    core_mask_i,
    output logic [DW-1:0] core_rdata_o,
    output logic          core_stall_o,
    dbus_if.master        bus,
    output logic          err_o
);

    dbus_state_e   r_state;
    dbus_state_e   w_state_nxt;
    logic          r_we;
    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_mask;
    logic [DW-1:0] r_rdata;

    logic          w_capture_req;
    logic          w_capture_rdata;
    logic [DW-1:0] w_rdata_nxt;
    logic          w_timeout_hit;
    logic          w_expired;
    logic          w_wdog_en;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture_req) begin
                r_we    <= core_we_i;
                r_addr  <= core_addr_i;
                r_wdata <= core_wdata_i;
                r_mask  <= core_mask_i;
            end
            if (w_capture_rdata) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_capture_req   = 1'b0;
        w_capture_rdata = 1'b0;
        w_rdata_nxt     = bus.bus_rdata_i;
        w_timeout_hit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (core_req_i) begin
                    w_capture_req = 1'b1;
                    w_state_nxt   = REQ;
                end
            end
            REQ: begin
                if (bus.bus_ready_i) begin
                    if (r_we) begin
                        w_state_nxt = DONE;
                    end else if (bus.bus_rvalid_i) begin
                        w_capture_rdata = 1'b1;
                        w_state_nxt     = DONE;
                    end else if (w_expired) begin
                        w_timeout_hit = 1'b1;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end else if (w_expired) begin
                    w_timeout_hit = 1'b1;
                end
            end
            RESP: begin
                if (bus.bus_rvalid_i) begin
                    w_capture_rdata = 1'b1;
                    w_state_nxt     = DONE;
                end else if (w_expired) begin
                    w_timeout_hit = 1'b1;
                end
            end
            DONE: begin
                // A request seen here belongs to the next instruction and is
                // picked up once back in IDLE.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A completed handshake always wins over an expiring watchdog.
        if (w_timeout_hit) begin
            w_state_nxt     = DONE;
            w_capture_rdata = !r_we;
            w_rdata_nxt     = DW'(ERR_RDATA);
        end
    end

    assign w_wdog_en = state_busy(r_state);

    // The IDLE term is gated so an asserted reset releases the core at once.
    assign core_stall_o = w_wdog_en || ((r_state == IDLE) && core_req_i && rst_i);
    assign core_rdata_o = r_rdata;

    assign bus.bus_valid_o = (r_state == REQ);
    assign bus.bus_we_o    = r_we;
    assign bus.bus_addr_o  = r_addr;
    assign bus.bus_wdata_o = r_wdata;
    assign bus.bus_mask_o  = r_mask;

`ifdef DBUS_TIMEOUT_EN
    logic r_err;

    dbus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (w_capture_req),
        .enable  (w_wdog_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout_hit;
        end
    end

    assign err_o = r_err;
`else
    logic [2:0] w_unused_cfg;

    assign w_unused_cfg = {w_timeout_hit, w_wdog_en, (TIMEOUT_CYCLES == 0)};
    assign w_expired    = 1'b0;
    assign err_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dbus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbus_bridge
//  Brief    : Randomised scoreboard bench for dbus_bridge with a bus responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_bridge;

`ifdef DBUS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
    localparam bit TB_WDOG    = 1'b1;
`else
    localparam int TB_TIMEOUT = 255;
    localparam bit TB_WDOG    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic [3:0]  core_mask_i;
    logic [31:0] core_rdata_o;
    logic        core_stall_o;
    logic        err_o;

    dbus_if #(.DW(32)) bus_if ();

    dbus_bridge #(
        .DW             (32),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_mask_i  (core_mask_i),
        .core_rdata_o (core_rdata_o),
        .core_stall_o (core_stall_o),
        .bus          (bus_if),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          vcyc;
    } req_t;

    typedef struct {
        int          stall;
        logic [31:0] rdata;
        logic        err;
    } done_t;

    typedef struct {
        int          rd;
        int          rv;
        logic [31:0] data;
        logic        we;
    } slv_t;

    req_t  req_q[$];
    done_t done_q[$];
    slv_t  sl_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic finish_bench();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Bus responder: ready after rd waiting cycles, read data rv cycles after.
    int   sl_phase = 0;
    int   sl_cnt   = 0;
    slv_t sl_cur;

    always @(negedge clk) begin
        bus_if.bus_ready_i  = 1'b0;
        bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i  = $urandom;
        if (sl_phase == 0 && bus_if.bus_valid_o && sl_q.size() > 0) begin
            sl_cur   = sl_q.pop_front();
            sl_cnt   = sl_cur.rd;
            sl_phase = 1;
        end
        if (sl_phase == 1) begin
            if (!bus_if.bus_valid_o) begin
                sl_phase = 0;
            end else if (sl_cnt == 0) begin
                bus_if.bus_ready_i = 1'b1;
                if (sl_cur.we) begin
                    sl_phase = 0;
                end else if (sl_cur.rv == 0) begin
                    bus_if.bus_rvalid_i = 1'b1;
                    bus_if.bus_rdata_i  = sl_cur.data;
                    sl_phase            = 0;
                end else begin
                    sl_cnt   = sl_cur.rv;
                    sl_phase = 2;
                end
            end else begin
                sl_cnt--;
            end
        end else if (sl_phase == 2) begin
            bus_if.bus_ready_i = 1'($urandom_range(0, 1));
            sl_cnt--;
            if (sl_cnt == 0) begin
                bus_if.bus_rvalid_i = 1'b1;
                bus_if.bus_rdata_i  = sl_cur.data;
                sl_phase            = 0;
            end
        end else begin
            bus_if.bus_ready_i  = 1'($urandom_range(0, 1));
            bus_if.bus_rvalid_i = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: compares every bus request and every completed access.
    bit          mon_en    = 1'b0;
    bit          mon_busy  = 1'b0;
    bit          mon_done  = 1'b0;
    int          mon_vcnt  = 0;
    int          mon_scnt  = 0;
    logic [31:0] mon_rdata = 32'h0;
    done_t       mon_d;

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            mon_done = 1'b0;
            if (bus_if.bus_valid_o) begin
                mon_vcnt++;
                if (req_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_request: got addr 0x%08h, expected no request", bus_if.bus_addr_o);
                end else begin
                    check("bus_we", 32'(bus_if.bus_we_o), 32'(req_q[0].we));
                    check("bus_addr", bus_if.bus_addr_o, req_q[0].addr);
                    check("bus_wdata", bus_if.bus_wdata_o, req_q[0].wdata);
                    check("bus_mask", 32'(bus_if.bus_mask_o), 32'(req_q[0].mask));
                    if (bus_if.bus_ready_i) begin
                        check("valid_cycles", mon_vcnt, req_q[0].vcyc);
                        void'(req_q.pop_front());
                        mon_vcnt = 0;
                    end
                end
            end else if (mon_vcnt != 0) begin
                if (req_q.size() > 0) begin
                    check("valid_cycles_abandoned", mon_vcnt, req_q[0].vcyc);
                    void'(req_q.pop_front());
                end
                mon_vcnt = 0;
            end

            if (core_stall_o) begin
                mon_scnt++;
                mon_busy = 1'b1;
            end else if (mon_busy) begin
                mon_done = 1'b1;
                mon_busy = 1'b0;
                if (done_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_completion: got stall %0d cycles, expected none", mon_scnt);
                end else begin
                    mon_d = done_q.pop_front();
                    check("stall_cycles", mon_scnt, mon_d.stall);
                    check("done_rdata", core_rdata_o, mon_d.rdata);
                    check("done_err", 32'(err_o), 32'(mon_d.err));
                    mon_rdata = mon_d.rdata;
                end
                mon_scnt = 0;
            end

            if (!mon_done) begin
                check("err_quiet", 32'(err_o), 32'h0);
                check("rdata_hold", core_rdata_o, mon_rdata);
            end
        end
    end

    // Reference model: access outcome derived from the bus response timing.
    logic [31:0] model_rdata = 32'h0;

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input int rd, input int rv,
                         input logic [31:0] data, input int gap);
        int busy_cyc;
        int vcyc;
        bit tmo;
        bit finished;
        busy_cyc = we ? rd + 1 : rd + 1 + rv;
        tmo      = TB_WDOG && (busy_cyc > TB_TIMEOUT);
        if (tmo) busy_cyc = TB_TIMEOUT;
        vcyc = rd + 1;
        if (TB_WDOG && vcyc > TB_TIMEOUT) vcyc = TB_TIMEOUT;
        if (!we) model_rdata = tmo ? 32'h0 : data;

        sl_q.push_back('{rd: rd, rv: rv, data: data, we: we});
        req_q.push_back('{we: we, addr: addr, wdata: wdata, mask: mask, vcyc: vcyc});
        done_q.push_back('{stall: 1 + busy_cyc, rdata: model_rdata, err: tmo});

        core_req_i   = 1'b1;
        core_we_i    = we;
        core_addr_i  = addr;
        core_wdata_i = wdata;
        core_mask_i  = mask;

        finished = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!core_stall_o) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            n_checks++;
            $display("FAIL access_complete: got stall still high after 300 cycles, expected release");
            finish_bench();
        end

        if (gap > 0) begin
            core_req_i   = 1'($urandom_range(0, 1));
            core_we_i    = 1'($urandom_range(0, 1));
            core_addr_i  = $urandom;
            core_wdata_i = $urandom;
            core_mask_i  = 4'($urandom);
            @(negedge clk);
            core_req_i = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic random_access(input int gap);
        issue(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, 32'(core_stall_o), 32'h0);
        check({tag, "_valid"}, 32'(bus_if.bus_valid_o), 32'h0);
        check({tag, "_err"}, 32'(err_o), 32'h0);
        check({tag, "_we"}, 32'(bus_if.bus_we_o), 32'h0);
        check({tag, "_addr"}, bus_if.bus_addr_o, 32'h0);
        check({tag, "_wdata"}, bus_if.bus_wdata_o, 32'h0);
        check({tag, "_mask"}, 32'(bus_if.bus_mask_o), 32'h0);
        check({tag, "_rdata"}, core_rdata_o, 32'h0);
    endtask

    initial begin
        #500000;
        n_checks++;
        $display("FAIL global_time_limit: got simulation still running, expected completion");
        finish_bench();
    end

    initial begin
        rst_i        = 1'b0;
        core_req_i   = 1'b1;
        core_we_i    = 1'b1;
        core_addr_i  = 32'hFFFF_FFFF;
        core_wdata_i = 32'hFFFF_FFFF;
        core_mask_i  = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        @(negedge clk);
        core_req_i = 1'b0;
        rst_i      = 1'b1;
        mon_en     = 1'b1;

        issue(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0, 0);
        issue(1'b0, 32'h0000_0204, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 1);
        issue(1'b0, 32'h0000_0208, 32'h0, 4'h3, 2, 2, 32'h8765_4321, 2);
        issue(1'b1, 32'h0000_0010, 32'h1111_1111, 4'h1, 0, 0, 32'h0, 0);
        issue(1'b1, 32'h0000_0014, 32'h2222_2222, 4'h2, 1, 0, 32'h0, 0);
        issue(1'b1, 32'h0000_0017, 32'h3333_3333, 4'hC, 0, 0, 32'h0, 1);

        for (int n = 0; n < 40; n++) begin
            random_access($urandom_range(0, 2));
        end

`ifdef DBUS_TIMEOUT_EN
        issue(1'b0, 32'h0000_0300, 32'h0, 4'hF, 100, 0, 32'hDEAD_BEEF, 1);
        issue(1'b0, 32'h0000_0304, 32'h0, 4'hF, 1, 1, 32'h0BAD_F00D, 0);
        issue(1'b1, 32'h0000_0308, 32'h5555_AAAA, 4'h3, 100, 0, 32'h0, 1);
`endif

        // Make sure the captured data is non-zero before resetting mid-access.
        issue(1'b0, 32'h0000_0380, 32'h0, 4'hF, 0, 1, 32'hF00D_CAFE, 1);

        sl_q.push_back('{rd: 0, rv: 6, data: 32'hA5A5_0001, we: 1'b0});
        req_q.push_back('{we: 1'b0, addr: 32'h0000_0400, wdata: 32'h0, mask: 4'hF, vcyc: 1});
        core_req_i   = 1'b1;
        core_we_i    = 1'b0;
        core_addr_i  = 32'h0000_0400;
        core_wdata_i = 32'h0;
        core_mask_i  = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_i  = 1'b0;
        #1;
        check_reset_outputs("resp_reset");
        req_q.delete();
        done_q.delete();
        mon_busy    = 1'b0;
        mon_scnt    = 0;
        mon_vcnt    = 0;
        mon_rdata   = 32'h0;
        model_rdata = 32'h0;
        @(negedge clk);
        #1;
        check("resp_reset_hold_stall", 32'(core_stall_o), 32'h0);
        @(negedge clk);
        core_req_i = 1'b0;
        rst_i      = 1'b1;
        mon_en     = 1'b1;
        repeat (8) @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            random_access($urandom_range(0, 2));
        end
        issue(1'b0, 32'h0000_0500, 32'h0, 4'hF, 1, 0, 32'h7777_0000, 2);

        finish_bench();
    end

endmodule
`default_nettype wire
